imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Registered, parametrised immediate generator for the RV32I/RV64I decode path. It takes the upper instruction bits (instr[31:7]) plus an immediate-format select and produces the XLEN-wide extended immediate behind a valid/ready handshake. It adds two formats to the base five (CSR zimm, shift amount), an explicit illegal-format flag, a two-entry skid buffer for full-throughput backpressure, and a flush. It sits between the decoder and the execute-stage operand mux.

## Interface
- XLEN, 32, datapath width; only 32 or 64 legal (elaboration error otherwise)
- TAG_W, 5, width of sideband tag carried alongside each immediate (e.g. rd / ROB id)
- CNT_W, 8, width of saturating illegal-format counter
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous discard of all buffered entries
- in_valid  input  1  request valid
- in_ready  output  1  request may be accepted this cycle
- instr  input  25  instruction bits [31:7]
- imm_src  input  3  format select
- in_tag  input  TAG_W  sideband tag
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- imm  output  XLEN  extended immediate
- out_tag  output  TAG_W  tag of the result
- out_illegal  output  1  result came from an illegal imm_src
- illegal_cnt  output  CNT_W  count of accepted illegal requests, saturating

## Operation
- Formats (imm_src), sign bit is instr[31] unless stated:
  - 000 I: sext(instr[31:20])
  - 001 S: sext({instr[31:25], instr[11:7]})
  - 010 B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0})
  - 011 J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0})
  - 100 U: {instr[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64
  - 101 Z: zext(instr[19:15])
  - 110 SH: zext(instr[24:20]) for XLEN=32; zext(instr[25:20]) for XLEN=64
  - 111: illegal; imm = 0, out_illegal = 1
- Extension happens combinationally on the input side. The registered result is {imm, tag, illegal}.
- Accept = in_valid & in_ready. Output handshake = out_valid & out_ready.
- State machine, which is the only control state:
  - EMPTY: accept -> ONE (out reg <= new).
  - ONE: accept & out_ready -> ONE (out reg <= new). Accept & !out_ready -> FULL (skid <= new). No accept & out_ready -> EMPTY. Otherwise hold.
  - FULL: in_ready = 0. out_ready -> ONE (out reg <= skid). Otherwise hold.
- in_ready = (state != FULL). It is decoded from the state register, so it does not depend combinationally on out_ready.
- out_valid = (state != EMPTY).
- Order is strictly FIFO. No entry is dropped or duplicated.
- illegal_cnt increments on each accepted request with imm_src = 111. It holds at 2^CNT_W-1 and is not cleared by flush.
- Flush forces EMPTY next cycle and overrides a same-cycle accept (that request is discarded). An out handshake in the flush cycle still counts as delivered. A discarded illegal request does not increment the counter.

## Timing
- Latency 1 cycle: a request accepted at edge N is on imm/out_valid after edge N. Throughput is 1 per cycle while out_ready = 1.
- Payload registers hold while !out_ready (stable-while-valid).
- Reset, any time including mid-transfer: state EMPTY, out_valid 0, imm 0, out_tag 0, out_illegal 0, illegal_cnt 0, skid contents 0. in_ready reads 1 during and after reset.
- Outputs are unaffected by instr/imm_src changes while not accepting.

## Structure
- Shared package `imm_gen_pkg` holds the imm_src localparam encodings (IMM_I … IMM_ILL) and the state encoding (ST_EMPTY, ST_ONE, ST_FULL). The decoder uses the same encodings.
- Sub-module `imm_extend_comb` is the pure combinational format decode (instr, imm_src -> imm, illegal), parametrised by XLEN. The top level adds the skid FSM, payload registers and counter.

## Test plan
- XLEN=32, instr = 0xFFF00093>>7, imm_src=000, out_ready=1 -> imm = 0xFFFFFFFF one cycle later, tag echoed.
- instr = 0xFE000EE3>>7, imm_src=010 -> imm = 0xFFFFFFFC. The same bits with imm_src=111 -> imm = 0, out_illegal = 1, illegal_cnt +1.
- U-type 0x800000B7: XLEN=32 -> 0x80000000; XLEN=64 -> 0xFFFFFFFF80000000.
- out_ready = 0, three back-to-back requests -> first two accepted, in_ready = 0 after the second, third stalled. Raising out_ready drains tags in order with no gap.
- State FULL, then flush with in_valid=1 -> next cycle out_valid = 0, in_ready = 1, flushed-cycle request never appears. Also: CNT_W=2 with five illegal requests -> illegal_cnt = 3.
- rst_n pulsed low asynchronously while FULL -> out_valid and illegal_cnt go to 0 immediately, in_ready = 1, and the first post-reset request completes normally.

Source files
------------

// File: rtl/imm_gen_pipe_pkg.sv
// Shared encodings for the immediate generator: format selects and the
// skid-buffer state encoding. The decoder imports the same package.
package imm_gen_pkg;

    // Immediate format select encodings
    localparam logic [2:0] IMM_I   = 3'd0;
    localparam logic [2:0] IMM_S   = 3'd1;
    localparam logic [2:0] IMM_B   = 3'd2;
    localparam logic [2:0] IMM_J   = 3'd3;
    localparam logic [2:0] IMM_U   = 3'd4;
    localparam logic [2:0] IMM_Z   = 3'd5;
    localparam logic [2:0] IMM_SH  = 3'd6;
    localparam logic [2:0] IMM_ILL = 3'd7;

    // Skid buffer occupancy: EMPTY (nothing held), ONE (output reg full),
    // FULL (output reg and skid reg both full)
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Request/response bundle of the immediate generator. The slave modport is
// the generator itself; the master modport is the decoder/consumer side.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [24:0]      instr;
    logic [2:0]       imm_src;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;
    logic [CNT_W-1:0] illegal_cnt;

    modport master (
        output in_valid, instr, imm_src, in_tag, out_ready,
        input  in_ready, out_valid, imm, out_tag, out_illegal, illegal_cnt
    );

    modport slave (
        input  in_valid, instr, imm_src, in_tag, out_ready,
        output in_ready, out_valid, imm, out_tag, out_illegal, illegal_cnt
    );
endinterface

// File: rtl/imm_gen_pipe_extend.sv
// Pure combinational immediate decode. instr holds instruction bits [31:7],
// so instruction bit b lives at instr[b-7] throughout this file.
module imm_extend_comb
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [24:0]     instr,
    input  logic [2:0]      imm_src,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    // Assemble the immediate for the selected format and extend to XLEN;
    // signed size casts sign-extend, unsigned ones zero-extend
    always_comb begin
        imm     = {XLEN{1'b0}};
        illegal = 1'b0;
        case (imm_src)
            IMM_I:   imm = XLEN'($signed(instr[24:13]));
            IMM_S:   imm = XLEN'($signed({instr[24:18], instr[4:0]}));
            IMM_B:   imm = XLEN'($signed({instr[24], instr[0], instr[23:18],
                                          instr[4:1], 1'b0}));
            IMM_J:   imm = XLEN'($signed({instr[24], instr[12:5], instr[13],
                                          instr[23:14], 1'b0}));
            IMM_U:   imm = XLEN'($signed({instr[24:5], 12'b0}));
            IMM_Z:   imm = XLEN'(instr[12:8]);
            IMM_SH:  imm = (XLEN == 64) ? XLEN'(instr[18:13]) : XLEN'(instr[17:13]);
            IMM_ILL: begin
                imm     = {XLEN{1'b0}};
                illegal = 1'b1;
            end
            default: begin
                imm     = {XLEN{1'b0}};
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: input-side combinational extension feeding
// a two-entry skid buffer (output reg + skid reg) so the producer sees
// in_ready purely from state, plus a saturating illegal-format counter.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    imm_gen_pipe_if.slave bus
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_r, state_s;
    logic [XLEN-1:0]  ext_imm_s;
    logic             ext_ill_s;
    logic             in_ready_s, accept_s, cnt_inc_s;
    logic             load_out_new_s, load_out_skid_s, load_skid_s;
    logic [XLEN-1:0]  out_imm_r, skid_imm_r;
    logic [TAG_W-1:0] out_tag_r, skid_tag_r;
    logic             out_ill_r, skid_ill_r;
    logic [CNT_W-1:0] cnt_r;

    imm_extend_comb #(.XLEN(XLEN)) u_extend (
        .instr   (bus.instr),
        .imm_src (bus.imm_src),
        .imm     (ext_imm_s),
        .illegal (ext_ill_s)
    );

    assign in_ready_s = (state_r != ST_FULL);
    assign accept_s   = bus.in_valid & in_ready_s;

    // Occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Next occupancy and payload load strobes; flush empties the buffer and
    // discards any same-cycle request
    always_comb begin
        state_s         = state_r;
        load_out_new_s  = 1'b0;
        load_out_skid_s = 1'b0;
        load_skid_s     = 1'b0;
        cnt_inc_s       = 1'b0;
        if (flush) begin
            state_s = ST_EMPTY;
        end else begin
            cnt_inc_s = accept_s & ext_ill_s & (cnt_r != CNT_MAX);
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_s        = ST_ONE;
                        load_out_new_s = 1'b1;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && bus.out_ready) begin
                        state_s        = ST_ONE;
                        load_out_new_s = 1'b1;
                    end else if (accept_s) begin
                        state_s     = ST_FULL;
                        load_skid_s = 1'b1;
                    end else if (bus.out_ready) begin
                        state_s = ST_EMPTY;
                    end else begin
                        state_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (bus.out_ready) begin
                        state_s         = ST_ONE;
                        load_out_skid_s = 1'b1;
                    end else begin
                        state_s = ST_FULL;
                    end
                end
                default: begin
                    state_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Output and skid payload registers; contents hold unless loaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_imm_r  <= {XLEN{1'b0}};
            out_tag_r  <= {TAG_W{1'b0}};
            out_ill_r  <= 1'b0;
            skid_imm_r <= {XLEN{1'b0}};
            skid_tag_r <= {TAG_W{1'b0}};
            skid_ill_r <= 1'b0;
        end else begin
            if (load_out_new_s) begin
                out_imm_r <= ext_imm_s;
                out_tag_r <= bus.in_tag;
                out_ill_r <= ext_ill_s;
            end else if (load_out_skid_s) begin
                out_imm_r <= skid_imm_r;
                out_tag_r <= skid_tag_r;
                out_ill_r <= skid_ill_r;
            end
            if (load_skid_s) begin
                skid_imm_r <= ext_imm_s;
                skid_tag_r <= bus.in_tag;
                skid_ill_r <= ext_ill_s;
            end
        end
    end

    // Saturating count of accepted illegal requests; flush does not clear it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_inc_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = (state_r != ST_EMPTY);
    assign bus.imm         = out_imm_r;
    assign bus.out_tag     = out_tag_r;
    assign bus.out_illegal = out_ill_r;
    assign bus.illegal_cnt = cnt_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an XLEN=32/CNT_W=8 instance and an XLEN=64/CNT_W=2
// instance driven with identical stimulus, each checked against a queue model.
module tb_imm_gen_pipe;

    typedef struct packed {
        logic [63:0] imm;
        logic [4:0]  tag;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [24:0] instr;
    logic [2:0]  imm_src;
    logic [4:0]  in_tag;

    int   checks = 0;
    int   failures = 0;
    exp_t q32[$];
    exp_t q64[$];
    int   cnt32 = 0;
    int   cnt64 = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(5), .CNT_W(8)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(5), .CNT_W(2)) bus64 ();

    assign bus32.in_valid  = in_valid;
    assign bus32.instr     = instr;
    assign bus32.imm_src   = imm_src;
    assign bus32.in_tag    = in_tag;
    assign bus32.out_ready = out_ready;
    assign bus64.in_valid  = in_valid;
    assign bus64.instr     = instr;
    assign bus64.imm_src   = imm_src;
    assign bus64.in_tag    = in_tag;
    assign bus64.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5), .CNT_W(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus32.slave)
    );
    imm_gen_pipe #(.XLEN(64), .TAG_W(5), .CNT_W(2)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus64.slave)
    );

    // Reference immediate from the full 32-bit instruction word using
    // arithmetic on the sign-extended word
    function automatic logic [63:0] ref_imm(input logic [24:0] ins, input logic [2:0] src,
                                            input int xlen);
        logic [31:0] w;
        longint      sw;
        longint      v;
        w  = {ins, 7'b0};
        sw = longint'(signed'(w));
        case (src)
            3'd0: v = sw >>> 20;
            3'd1: v = (sw >>> 25) * 32 + longint'(w[11:7]);
            3'd2: v = (sw >>> 31) * 4096 + longint'(w[7]) * 2048
                      + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
            3'd3: v = (sw >>> 31) * 1048576 + longint'(w[19:12]) * 4096
                      + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
            3'd4: v = (sw >>> 12) * 4096;
            3'd5: v = longint'(w[19:15]);
            3'd6: v = (xlen == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
            default: v = 0;
        endcase
        if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return v;
    endfunction

    // One clock: model decisions from pre-edge state, then update after edge
    task automatic tick();
        bit   acc32, acc64, hs32, hs64;
        exp_t e;
        acc32 = in_valid && (q32.size() < 2);
        acc64 = in_valid && (q64.size() < 2);
        hs32  = out_ready && (q32.size() > 0);
        hs64  = out_ready && (q64.size() > 0);
        @(posedge clk);
        if (hs32) void'(q32.pop_front());
        if (hs64) void'(q64.pop_front());
        if (flush) begin
            q32.delete();
            q64.delete();
        end else begin
            if (acc32) begin
                e.imm = ref_imm(instr, imm_src, 32);
                e.tag = in_tag;
                e.ill = (imm_src == 3'd7);
                q32.push_back(e);
                if (e.ill && cnt32 < 255) cnt32++;
            end
            if (acc64) begin
                e.imm = ref_imm(instr, imm_src, 64);
                e.tag = in_tag;
                e.ill = (imm_src == 3'd7);
                q64.push_back(e);
                if (e.ill && cnt64 < 3) cnt64++;
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] word, input logic [2:0] src, input logic [4:0] tag);
        instr     = word[31:7];
        imm_src   = src;
        in_tag    = tag;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = 25'd0; imm_src = 3'd0; in_tag = 5'd0;
        #2;
        checks++; if (bus32.in_ready !== 1'b1 || bus64.in_ready !== 1'b1) begin
            failures++; $display("FAIL rst_in_ready_during got=%b/%b exp=1", bus32.in_ready, bus64.in_ready);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus32.out_valid !== 1'b0 || bus32.imm !== 32'd0 || bus32.out_tag !== 5'd0
                      || bus32.out_illegal !== 1'b0 || bus32.illegal_cnt !== 8'd0 || bus32.in_ready !== 1'b1) begin
            failures++; $display("FAIL rst_state32 got v=%b imm=%h tag=%h ill=%b cnt=%0d rdy=%b exp zeros,rdy=1",
                bus32.out_valid, bus32.imm, bus32.out_tag, bus32.out_illegal, bus32.illegal_cnt, bus32.in_ready);
        end
        checks++; if (bus64.out_valid !== 1'b0 || bus64.imm !== 64'd0 || bus64.illegal_cnt !== 2'd0) begin
            failures++; $display("FAIL rst_state64 got v=%b imm=%h cnt=%0d exp 0", bus64.out_valid, bus64.imm, bus64.illegal_cnt);
        end
    endtask

    task automatic test_formats();
        send(32'hFFF00093, 3'd0, 5'd3);
        checks++; if (bus32.out_valid !== 1'b1 || bus32.imm !== 32'hFFFF_FFFF || bus32.out_tag !== 5'd3) begin
            failures++; $display("FAIL fmt_i32 got v=%b imm=%h tag=%0d exp 1/ffffffff/3", bus32.out_valid, bus32.imm, bus32.out_tag);
        end
        checks++; if (bus64.imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            failures++; $display("FAIL fmt_i64 got=%h exp=ffffffffffffffff", bus64.imm);
        end
        tick();
        send(32'hFE000EE3, 3'd2, 5'd4);
        checks++; if (bus32.imm !== 32'hFFFF_FFFC || bus64.imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            failures++; $display("FAIL fmt_b got=%h/%h exp=fffffffc", bus32.imm, bus64.imm);
        end
        tick();
        send(32'hFE000EE3, 3'd7, 5'd5);
        checks++; if (bus32.imm !== 32'd0 || bus32.out_illegal !== 1'b1 || bus32.illegal_cnt !== 8'd1
                      || bus64.imm !== 64'd0 || bus64.illegal_cnt !== 2'd1) begin
            failures++; $display("FAIL fmt_ill got imm=%h ill=%b cnt=%0d cnt64=%0d exp 0/1/1/1",
                bus32.imm, bus32.out_illegal, bus32.illegal_cnt, bus64.illegal_cnt);
        end
        tick();
        send(32'h800000B7, 3'd4, 5'd6);
        checks++; if (bus32.imm !== 32'h8000_0000 || bus64.imm !== 64'hFFFF_FFFF_8000_0000) begin
            failures++; $display("FAIL fmt_u got=%h/%h exp=80000000/ffffffff80000000", bus32.imm, bus64.imm);
        end
        tick();
        send(32'h03F05013, 3'd6, 5'd7);
        checks++; if (bus32.imm !== 32'd31 || bus64.imm !== 64'd63) begin
            failures++; $display("FAIL fmt_sh got=%0d/%0d exp=31/63", bus32.imm, bus64.imm);
        end
        tick();
        send(32'hFFFFF073, 3'd5, 5'd8);
        checks++; if (bus32.imm !== 32'd31 || bus64.imm !== 64'd31 || bus32.out_illegal !== 1'b0) begin
            failures++; $display("FAIL fmt_z got=%h/%h ill=%b exp=1f/1f/0", bus32.imm, bus64.imm, bus32.out_illegal);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0; in_valid = 1'b1; imm_src = 3'd0; instr = 25'h0ABCDE;
        in_tag = 5'd10; tick();
        checks++; if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b1 || bus32.out_tag !== 5'd10) begin
            failures++; $display("FAIL b2b_first got rdy=%b v=%b tag=%0d exp 1/1/10", bus32.in_ready, bus32.out_valid, bus32.out_tag);
        end
        in_tag = 5'd11; tick();
        checks++; if (bus32.in_ready !== 1'b0 || bus64.in_ready !== 1'b0 || bus32.out_tag !== 5'd10) begin
            failures++; $display("FAIL b2b_full got rdy=%b/%b tag=%0d exp 0/0/10", bus32.in_ready, bus64.in_ready, bus32.out_tag);
        end
        in_tag = 5'd12; instr = 25'h1FFFFFF; tick();
        checks++; if (bus32.in_ready !== 1'b0 || bus32.out_tag !== 5'd10 || bus32.imm !== ref_imm(25'h0ABCDE, 3'd0, 32)) begin
            failures++; $display("FAIL b2b_stall got rdy=%b tag=%0d imm=%h exp 0/10", bus32.in_ready, bus32.out_tag, bus32.imm);
        end
        in_valid = 1'b0; out_ready = 1'b1; tick();
        checks++; if (bus32.out_valid !== 1'b1 || bus32.out_tag !== 5'd11 || bus32.in_ready !== 1'b1) begin
            failures++; $display("FAIL b2b_drain1 got v=%b tag=%0d rdy=%b exp 1/11/1", bus32.out_valid, bus32.out_tag, bus32.in_ready);
        end
        tick();
        checks++; if (bus32.out_valid !== 1'b0 || bus64.out_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_drain2 got v=%b/%b exp 0", bus32.out_valid, bus64.out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; imm_src = 3'd0;
        in_tag = 5'd20; tick();
        in_tag = 5'd21; tick();
        flush = 1'b1; imm_src = 3'd7; in_tag = 5'd22; tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1 || bus32.illegal_cnt !== 8'd1) begin
            failures++; $display("FAIL flush_full got v=%b rdy=%b cnt=%0d exp 0/1/1", bus32.out_valid, bus32.in_ready, bus32.illegal_cnt);
        end
        in_valid = 1'b1; imm_src = 3'd0; in_tag = 5'd23; tick();
        flush = 1'b1; imm_src = 3'd7; in_tag = 5'd24; tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (bus32.out_valid !== 1'b0 || bus32.illegal_cnt !== 8'd1 || bus64.illegal_cnt !== 2'd1) begin
            failures++; $display("FAIL flush_one got v=%b cnt=%0d/%0d exp 0/1/1", bus32.out_valid, bus32.illegal_cnt, bus64.illegal_cnt);
        end
        tick();
        checks++; if (bus32.out_valid !== 1'b0 || bus64.out_valid !== 1'b0) begin
            failures++; $display("FAIL flush_ghost got v=%b/%b exp 0", bus32.out_valid, bus64.out_valid);
        end
    endtask

    task automatic test_saturate();
        out_ready = 1'b1; in_valid = 1'b1; imm_src = 3'd7;
        for (int i = 0; i < 5; i++) begin
            in_tag = 5'(i); tick();
        end
        in_valid = 1'b0; tick();
        checks++; if (bus64.illegal_cnt !== 2'd3 || bus32.illegal_cnt !== 8'd6) begin
            failures++; $display("FAIL sat_cnt got=%0d/%0d exp=3/6", bus64.illegal_cnt, bus32.illegal_cnt);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; in_valid = 1'b1; imm_src = 3'd1;
        in_tag = 5'd1; tick();
        in_tag = 5'd2; tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus32.out_valid !== 1'b0 || bus32.illegal_cnt !== 8'd0 || bus32.in_ready !== 1'b1
                      || bus64.out_valid !== 1'b0 || bus64.illegal_cnt !== 2'd0 || bus32.imm !== 32'd0) begin
            failures++; $display("FAIL arst_imm got v=%b cnt=%0d rdy=%b v64=%b cnt64=%0d exp 0/0/1/0/0",
                bus32.out_valid, bus32.illegal_cnt, bus32.in_ready, bus64.out_valid, bus64.illegal_cnt);
        end
        #1 rst_n = 1'b1;
        q32.delete(); q64.delete(); cnt32 = 0; cnt64 = 0;
        @(negedge clk);
        send(32'hFFF00093, 3'd0, 5'd9);
        checks++; if (bus32.out_valid !== 1'b1 || bus32.imm !== 32'hFFFF_FFFF || bus32.out_tag !== 5'd9) begin
            failures++; $display("FAIL arst_after got v=%b imm=%h tag=%0d exp 1/ffffffff/9", bus32.out_valid, bus32.imm, bus32.out_tag);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            instr     = 25'($urandom);
            imm_src   = 3'($urandom_range(0, 7));
            in_tag    = 5'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            tick();
            checks++; if (bus32.out_valid !== (q32.size() > 0) || bus32.in_ready !== (q32.size() < 2)
                          || bus32.illegal_cnt !== 8'(cnt32)) begin
                failures++; $display("FAIL rnd_ctl32 cyc=%0d got v=%b rdy=%b cnt=%0d exp size=%0d cnt=%0d",
                    c, bus32.out_valid, bus32.in_ready, bus32.illegal_cnt, q32.size(), cnt32);
            end
            checks++; if (bus64.out_valid !== (q64.size() > 0) || bus64.in_ready !== (q64.size() < 2)
                          || bus64.illegal_cnt !== 2'(cnt64)) begin
                failures++; $display("FAIL rnd_ctl64 cyc=%0d got v=%b rdy=%b cnt=%0d exp size=%0d cnt=%0d",
                    c, bus64.out_valid, bus64.in_ready, bus64.illegal_cnt, q64.size(), cnt64);
            end
            if (q32.size() > 0) begin
                checks++; if (bus32.imm !== q32[0].imm[31:0] || bus32.out_tag !== q32[0].tag
                              || bus32.out_illegal !== q32[0].ill) begin
                    failures++; $display("FAIL rnd_data32 cyc=%0d got %h/%0d/%b exp %h/%0d/%b", c,
                        bus32.imm, bus32.out_tag, bus32.out_illegal, q32[0].imm[31:0], q32[0].tag, q32[0].ill);
                end
            end
            if (q64.size() > 0) begin
                checks++; if (bus64.imm !== q64[0].imm || bus64.out_tag !== q64[0].tag
                              || bus64.out_illegal !== q64[0].ill) begin
                    failures++; $display("FAIL rnd_data64 cyc=%0d got %h/%0d/%b exp %h/%0d/%b", c,
                        bus64.imm, bus64.out_tag, bus64.out_illegal, q64[0].imm, q64[0].tag, q64[0].ill);
                end
            end
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_formats();
        test_back_to_back();
        test_flush();
        test_saturate();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
